// File: rtl/clk_gate_pkg.sv
// Shared types and helpers for the clock-gate enable controller.
package clk_gate_pkg;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        COUNT = 2'd1,
        GATED = 2'd2,
        WAKE  = 2'd3
    } cg_state_t;

    localparam int DEF_IDLE_CYCLES = 16;
    localparam int DEF_WAKE_CYCLES = 2;

    // Increment that sticks at max instead of wrapping.
    function automatic logic [31:0] sat_inc(input logic [31:0] val, input logic [31:0] max);
        return (val >= max) ? val : val + 32'd1;
    endfunction

endpackage

// File: rtl/clk_gate_ctrl_timer.sv
// Loadable down-counter shared by the idle countdown and the wake settling delay.
module cg_timer #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         dec,
    output logic [W-1:0] count,
    output logic         is_one
);

    logic [W-1:0] count_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_reg <= '0;
        end else if (load) begin
            count_reg <= load_val;
        end else if (dec && (count_reg != '0)) begin
            count_reg <= count_reg - W'(1);
        end
    end

    assign count  = count_reg;
    assign is_one = (count_reg == W'(1));

endmodule

// File: rtl/clk_gate_ctrl.sv
// Registered ICG enable: gates after a run of idle cycles, wakes on activity with a settling delay.
module clk_gate_ctrl
    import clk_gate_pkg::*;
#(
    parameter int IDLE_CYCLES = DEF_IDLE_CYCLES,
    parameter int WAKE_CYCLES = DEF_WAKE_CYCLES,
    parameter int CNT_W       = $clog2(((IDLE_CYCLES > WAKE_CYCLES) ? IDLE_CYCLES : WAKE_CYCLES) + 1),
    parameter int STAT_W      = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              busy,
    input  logic              req,
    input  logic              force_on,
    output logic              en,
    output logic              ready,
    output logic              gated,
    output logic [STAT_W-1:0] gate_count
);

    localparam logic [STAT_W-1:0] STAT_MAX = '1;

    cg_state_t         state_reg;
    logic              en_reg;
    logic              ready_reg;
    logic              gated_reg;
    logic [STAT_W-1:0] gate_count_reg;
    logic [STAT_W-1:0] gate_count_next;

    logic              idle;
    logic              wake;
    logic              timer_load;
    logic [CNT_W-1:0]  timer_load_val;
    logic              timer_dec;
    logic [CNT_W-1:0]  timer_count;
    logic              timer_is_one;

    assign idle = !busy && !req && !force_on;
    assign wake = busy || req || force_on;
    assign gate_count_next = STAT_W'(sat_inc(32'(gate_count_reg), 32'(STAT_MAX)));

    always_comb begin
        timer_load     = 1'b0;
        timer_load_val = '0;
        timer_dec      = 1'b0;
        case (state_reg)
            RUN: begin
                if (idle) begin
                    timer_load     = 1'b1;
                    timer_load_val = CNT_W'(IDLE_CYCLES - 1);
                end
            end
            COUNT:   timer_dec = idle;
            GATED: begin
                if (wake) begin
                    timer_load     = 1'b1;
                    timer_load_val = CNT_W'(WAKE_CYCLES);
                end
            end
            WAKE:    timer_dec = 1'b1;
            default: timer_dec = 1'b0;
        endcase
    end

    cg_timer #(.W(CNT_W)) u_timer (
        .clk      (clk),
        .rst      (rst),
        .load     (timer_load),
        .load_val (timer_load_val),
        .dec      (timer_dec),
        .count    (timer_count),
        .is_one   (timer_is_one)
    );

    // Outputs are flops so the ICG latch never sees a combinational enable.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg      <= RUN;
            en_reg         <= 1'b1;
            ready_reg      <= 1'b1;
            gated_reg      <= 1'b0;
            gate_count_reg <= '0;
        end else begin
            case (state_reg)
                RUN: begin
                    if (idle) begin
                        if (IDLE_CYCLES == 1) begin
                            state_reg      <= GATED;
                            en_reg         <= 1'b0;
                            ready_reg      <= 1'b0;
                            gated_reg      <= 1'b1;
                            gate_count_reg <= gate_count_next;
                        end else begin
                            state_reg <= COUNT;
                        end
                    end
                end
                COUNT: begin
                    if (!idle) begin
                        state_reg <= RUN;
                    end else if (timer_is_one) begin
                        state_reg      <= GATED;
                        en_reg         <= 1'b0;
                        ready_reg      <= 1'b0;
                        gated_reg      <= 1'b1;
                        gate_count_reg <= gate_count_next;
                    end
                end
                GATED: begin
                    if (wake) begin
                        en_reg    <= 1'b1;
                        gated_reg <= 1'b0;
                        if (WAKE_CYCLES == 0) begin
                            state_reg <= RUN;
                            ready_reg <= 1'b1;
                        end else begin
                            state_reg <= WAKE;
                        end
                    end
                end
                WAKE: begin
                    if (timer_is_one) begin
                        state_reg <= RUN;
                        ready_reg <= 1'b1;
                    end
                end
                default: state_reg <= RUN;
            endcase
        end
    end

    assign en         = en_reg;
    assign ready      = ready_reg;
    assign gated      = gated_reg;
    assign gate_count = gate_count_reg;

    wire unused_timer = ^timer_count;

endmodule
